// File: rtl/nibbler_ctrl.sv
// Sequencer/decoder for the Nibbler 4-bit CPU: FETCH -> EXEC [-> MEM] -> FETCH.
// Every strobe is a combinational decode of the registered phase, opcode and flags.
module nibbler_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic [1:0] flags,
    output logic [1:0] phase,
    output logic       loadIR,
    output logic       incPC,
    output logic       loadPC,
    output logic       loadA,
    output logic       loadFlags,
    output logic [1:0] aluSel,
    output logic       oeOprnd,
    output logic       oeIN,
    output logic       csRAM,
    output logic       weRAM,
    output logic       loadOut
);

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXEC    = 2'b01,
        MEM     = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_NANDI = 4'hE;
    localparam logic [3:0] OP_NANDM = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;
    localparam logic [1:0] ALU_CMP  = 2'b11;

    state_e state_q;
    state_e state_d;
    logic   flag_c;
    logic   flag_z;

    assign flag_c = flags[1];
    assign flag_z = flags[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = FETCH;
        phase     = state_q;
        loadIR    = 1'b0;
        incPC     = 1'b0;
        loadPC    = 1'b0;
        loadA     = 1'b0;
        loadFlags = 1'b0;
        aluSel    = ALU_PASS;
        oeOprnd   = 1'b0;
        oeIN      = 1'b0;
        csRAM     = 1'b0;
        weRAM     = 1'b0;
        loadOut   = 1'b0;

        case (state_q)
            FETCH: begin
                if (run) begin
                    loadIR  = 1'b1;
                    incPC   = 1'b1;
                    state_d = EXEC;
                end else begin
                    state_d = FETCH;
                end
            end

            EXEC: begin
                case (opcode)
                    OP_JC:    loadPC = flag_c;
                    OP_JNC:   loadPC = ~flag_c;
                    OP_JZ:    loadPC = flag_z;
                    OP_JNZ:   loadPC = ~flag_z;
                    OP_JMP:   loadPC = 1'b1;
                    OP_LIT: begin
                        oeOprnd = 1'b1;
                        loadA   = 1'b1;
                    end
                    OP_IN: begin
                        oeIN  = 1'b1;
                        loadA = 1'b1;
                    end
                    OP_ADDI: begin
                        oeOprnd   = 1'b1;
                        aluSel    = ALU_ADD;
                        loadA     = 1'b1;
                        loadFlags = 1'b1;
                    end
                    OP_NANDI: begin
                        oeOprnd = 1'b1;
                        aluSel  = ALU_NAND;
                        loadA   = 1'b1;
                    end
                    OP_CMPI: begin
                        oeOprnd   = 1'b1;
                        aluSel    = ALU_CMP;
                        loadFlags = 1'b1;
                    end
                    OP_OUT:   loadOut = 1'b1;
                    // Memory ops only present the address here; the data phase follows in MEM.
                    OP_LD, OP_ST, OP_CMPM, OP_ADDM, OP_NANDM: begin
                        csRAM   = 1'b1;
                        state_d = MEM;
                    end
                endcase
            end

            MEM: begin
                csRAM = 1'b1;
                case (opcode)
                    OP_LD:    loadA = 1'b1;
                    OP_ST:    weRAM = 1'b1;
                    OP_CMPM: begin
                        aluSel    = ALU_CMP;
                        loadFlags = 1'b1;
                    end
                    OP_ADDM: begin
                        aluSel    = ALU_ADD;
                        loadA     = 1'b1;
                        loadFlags = 1'b1;
                    end
                    OP_NANDM: begin
                        aluSel = ALU_NAND;
                        loadA  = 1'b1;
                    end
                    default: ;
                endcase
            end

            default: state_d = FETCH;
        endcase

        // Reset overrides the decode so an aborted instruction never leaks a strobe.
        if (reset) begin
            state_d   = FETCH;
            phase     = FETCH;
            loadIR    = 1'b0;
            incPC     = 1'b0;
            loadPC    = 1'b0;
            loadA     = 1'b0;
            loadFlags = 1'b0;
            aluSel    = ALU_PASS;
            oeOprnd   = 1'b0;
            oeIN      = 1'b0;
            csRAM     = 1'b0;
            weRAM     = 1'b0;
            loadOut   = 1'b0;
        end
    end

endmodule

// File: tb/tb_nibbler_ctrl.sv
// Bench for nibbler_ctrl: directed and random instruction streams, with a queue-based
// scoreboard fed by an instruction-level reference model.
module tb_nibbler_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic [1:0] flags;
    logic [1:0] phase;
    logic       loadIR, incPC, loadPC, loadA, loadFlags;
    logic [1:0] aluSel;
    logic       oeOprnd, oeIN, csRAM, weRAM, loadOut;

    nibbler_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .flags(flags),
        .phase(phase), .loadIR(loadIR), .incPC(incPC), .loadPC(loadPC),
        .loadA(loadA), .loadFlags(loadFlags), .aluSel(aluSel),
        .oeOprnd(oeOprnd), .oeIN(oeIN), .csRAM(csRAM), .weRAM(weRAM),
        .loadOut(loadOut)
    );

    always #5 clk = ~clk;

    // {phase[1:0], loadIR, incPC, loadPC, loadA, loadFlags, aluSel[1:0], oeOprnd, oeIN, csRAM, weRAM, loadOut}
    logic [13:0] act;
    assign act = {phase, loadIR, incPC, loadPC, loadA, loadFlags, aluSel,
                  oeOprnd, oeIN, csRAM, weRAM, loadOut};

    int n_cmp = 0;
    int n_bad = 0;
    logic [13:0] expq[$];

    // Opcode sets, one bit per opcode value.
    localparam logic [15:0] S_MEMOP   = 16'h88C8; // CMPM LD ST ADDM NANDM
    localparam logic [15:0] S_EXEC_A  = 16'h4430; // LIT IN ADDI NANDI
    localparam logic [15:0] S_EXEC_F  = 16'h0404; // CMPI ADDI
    localparam logic [15:0] S_EXEC_OP = 16'h4414; // CMPI LIT ADDI NANDI
    localparam logic [15:0] S_MEM_A   = 16'h8840; // LD ADDM NANDM
    localparam logic [15:0] S_MEM_F   = 16'h0808; // CMPM ADDM

    function automatic logic in_set(input logic [15:0] s, input logic [3:0] op);
        return s[op];
    endfunction

    // Pairs 2/3 compare, A/B add, E/F nand; everything else passes B.
    function automatic logic [1:0] alu_of(input logic [3:0] op);
        case (op[3:1])
            3'd1:    return 2'b11;
            3'd5:    return 2'b01;
            3'd7:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic jump_taken(input logic [3:0] op, input logic [1:0] fl);
        case (op)
            4'h0:    return fl[1];
            4'h1:    return ~fl[1];
            4'h8:    return fl[0];
            4'h9:    return ~fl[0];
            4'hC:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [13:0] exp_fetch();
        logic [13:0] v = '0;
        v[11] = 1'b1;
        v[10] = 1'b1;
        return v;
    endfunction

    function automatic logic [13:0] exp_exec(input logic [3:0] op, input logic [1:0] fl);
        logic [13:0] v = '0;
        v[13:12] = 2'b01;
        if (in_set(S_MEMOP, op)) begin
            v[2] = 1'b1;
            return v;
        end
        v[9] = jump_taken(op, fl);
        v[8] = in_set(S_EXEC_A, op);
        v[7] = in_set(S_EXEC_F, op);
        if (v[8] || v[7]) v[6:5] = alu_of(op);
        v[4] = in_set(S_EXEC_OP, op);
        v[3] = (op == 4'h5);
        v[0] = (op == 4'hD);
        return v;
    endfunction

    function automatic logic [13:0] exp_mem(input logic [3:0] op);
        logic [13:0] v = '0;
        v[13:12] = 2'b10;
        v[2] = 1'b1;
        v[1] = (op == 4'h7);
        v[8] = in_set(S_MEM_A, op);
        v[7] = in_set(S_MEM_F, op);
        if (v[8] || v[7]) v[6:5] = alu_of(op);
        return v;
    endfunction

    task automatic drive_cycle(input logic r, input logic [3:0] op,
                               input logic [1:0] fl, input logic [13:0] e);
        @(posedge clk);
        #1;
        run    = r;
        opcode = op;
        flags  = fl;
        expq.push_back(e);
    endtask

    task automatic instr(input logic [3:0] op, input logic [1:0] fl_e, input logic [1:0] fl_m,
                         input int stalls, input bit rst_mid);
        for (int i = 0; i < stalls; i++)
            drive_cycle(1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), '0);
        drive_cycle(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), exp_fetch());
        drive_cycle(1'($urandom_range(0, 1)), op, fl_e, exp_exec(op, fl_e));
        if (in_set(S_MEMOP, op)) begin
            drive_cycle(1'($urandom_range(0, 1)), op, fl_m, exp_mem(op));
            if (rst_mid) begin
                @(negedge clk);
                #1;
                reset = 1'b1;
                #1;
                n_cmp++;
                if (act !== 14'h0) begin
                    n_bad++;
                    $display("FAIL async_reset_in_mem: got %h expected %h", act, 14'h0);
                end
                run = 1'b0;
                #1;
                reset = 1'b0;
            end
        end
    endtask

    // Monitor: every negedge the DUT presents one cycle of outputs.
    initial begin
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, act, e);
                end
                n_cmp++;
                if (loadPC && incPC) begin
                    n_bad++;
                    $display("FAIL pc_exclusive @%0t: got loadPC=%b incPC=%b expected not both 1",
                             $time, loadPC, incPC);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        reset  = 1'b1;
        run    = 1'b1;
        opcode = 4'h4;
        flags  = 2'b00;
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), '0);
        @(negedge clk);
        #1;
        run   = 1'b0;
        reset = 1'b0;

        instr(4'h4, 2'b00, 2'b00, 0, 1'b0);  // LIT
        instr(4'h0, 2'b10, 2'b00, 0, 1'b0);  // JC taken
        instr(4'h0, 2'b00, 2'b00, 0, 1'b0);  // JC not taken
        instr(4'h8, 2'b01, 2'b00, 0, 1'b0);  // JZ taken
        instr(4'h8, 2'b00, 2'b00, 0, 1'b0);  // JZ not taken
        instr(4'h9, 2'b01, 2'b00, 0, 1'b0);  // JNZ not taken
        instr(4'h9, 2'b00, 2'b00, 0, 1'b0);  // JNZ taken
        instr(4'h7, 2'b00, 2'b11, 0, 1'b0);  // ST
        instr(4'hB, 2'b00, 2'b11, 0, 1'b0);  // ADDM, flags toggled in MEM
        instr(4'h5, 2'b01, 2'b00, 4, 1'b0);  // IN after 4 stall cycles
        instr(4'h6, 2'b00, 2'b01, 0, 1'b1);  // LD aborted by async reset in MEM
        instr(4'hC, 2'b00, 2'b00, 0, 1'b0);  // JMP right after reset

        for (int k = 0; k < 400; k++) begin
            op = 4'($urandom_range(0, 15));
            instr(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                  in_set(S_MEMOP, op) && ($urandom_range(0, 15) == 0));
        end

        repeat (2) @(posedge clk);
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibbler_ctrl.md
NIBBLER_CTRL -- requirements
Module: nibbler_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 run  input  1  1 = sequencer may leave FETCH; 0 = hold in FETCH.
REQ-004 opcode  input  4  instruction register opcode field; stable from the cycle after FETCH.
REQ-005 flags  input  2  Flags register output: flags[1] = C, flags[0] = Z.
REQ-006 phase  output  2  state encoding: 00 FETCH, 01 EXEC, 10 MEM; 11 is unused.
REQ-007 loadIR  output  1  latch instruction word into the IR.
REQ-008 incPC  output  1  increment the PC.
REQ-009 loadPC  output  1  load the PC from the operand (jump taken).
REQ-010 loadA  output  1  load the accumulator from the ALU result.
REQ-011 loadFlags  output  1  load C/Z into the Flags register.
REQ-012 aluSel  output  2  ALU op: 00 pass B, 01 ADD, 10 NAND, 11 CMP (A-B).
REQ-013 oeOprnd  output  1  drive the immediate operand onto the B bus.
REQ-014 oeIN  output  1  drive the input port onto the B bus.
REQ-015 csRAM  output  1  RAM chip select (address = operand).
REQ-016 weRAM  output  1  RAM write enable; accumulator drives RAM data.
REQ-017 loadOut  output  1  latch the accumulator into the output port.

Function
REQ-018 Opcode map: 0 JC, 1 JNC, 2 CMPI, 3 CMPM, 4 LIT, 5 IN, 6 LD, 7 ST, 8 JZ, 9 JNZ, A ADDI, B ADDM, C JMP, D OUT, E NANDI, F NANDM.
REQ-019 All outputs are a decode of the registered state, opcode and flags. Any output not listed for a state/opcode is 0.
REQ-020 FETCH with run=1 asserts loadIR=1 and incPC=1, then moves to EXEC.
REQ-021 FETCH with run=0 keeps all strobes 0 and stays in FETCH. run is sampled only in FETCH.
REQ-022 EXEC for immediate/register ops asserts the listed signals, then returns to FETCH:
- LIT: oeOprnd, aluSel=00, loadA.
- IN: oeIN, aluSel=00, loadA.
- ADDI: oeOprnd, aluSel=01, loadA, loadFlags.
- NANDI: oeOprnd, aluSel=10, loadA.
- CMPI: oeOprnd, aluSel=11, loadFlags.
- OUT: loadOut.
REQ-023 EXEC jumps assert loadPC=1 iff the condition holds, then return to FETCH:
- JC: C=1. JNC: C=0. JZ: Z=1. JNZ: Z=0. JMP: always.
- Conditions use the flags value sampled during EXEC.
REQ-024 EXEC for LD, ST, CMPM, ADDM and NANDM asserts csRAM=1 only (address setup), then moves to MEM.
REQ-025 MEM asserts csRAM=1 plus the op-specific signals, then returns to FETCH:
- LD: aluSel=00, loadA.
- ST: weRAM.
- CMPM: aluSel=11, loadFlags.
- ADDM: aluSel=01, loadA, loadFlags.
- NANDM: aluSel=10, loadA.
REQ-026 Instruction latency:
- 2 cycles (FETCH+EXEC) for every op except LD/ST/CMPM/ADDM/NANDM.
- 3 cycles (FETCH+EXEC+MEM) for LD/ST/CMPM/ADDM/NANDM.
REQ-027 loadPC and incPC are never both 1 in the same cycle. weRAM=1 only in MEM with opcode 7.
REQ-028 Illegal state 11 asserts all strobes 0 and moves to FETCH on the next edge.
REQ-029 A change of opcode or flags in EXEC or MEM affects only the same-cycle combinational outputs, never the state sequence, except the EXEC→MEM choice made from the opcode value in EXEC.

Reset
REQ-030 While reset=1: state = FETCH, phase=00, and every strobe output, including aluSel=00, is forced to 0, regardless of clk.
REQ-031 Reset asserted mid-instruction (EXEC or MEM) aborts the instruction immediately with no further strobes.
REQ-032 After reset deasserts, the first rising edge with run=1 begins FETCH behaviour (loadIR=1, incPC=1) in that cycle.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, run=1, opcode=4 (LIT): cycle1 loadIR=1, incPC=1, phase=00; cycle2 oeOprnd=1, loadA=1, aluSel=00, phase=01; cycle3 phase=00.
- opcode=0 (JC) with flags=10: loadPC=1 in EXEC. Same with flags=00: loadPC=0. Repeat for JZ/JNZ using flags=01/00.
- opcode=7 (ST): EXEC csRAM=1, weRAM=0; MEM csRAM=1, weRAM=1; back to FETCH after 3 cycles total.
- opcode=B (ADDM): MEM asserts csRAM=1, aluSel=01, loadA=1, loadFlags=1. Flags toggled in MEM do not alter the sequence.
- run=0 for 4 cycles in FETCH: phase stays 00 and all strobes stay 0. run=1 resumes with loadIR=1 on the next cycle.
- Reset pulsed asynchronously (between clock edges) during MEM of LD: all outputs go 0 immediately and phase=00. Once reset is released, FETCH resumes.
